ar4_job_scheduler: RTL and testbench
====================================

# ar4_job_scheduler

Sequencer and two-port arbiter for the four-register shift/add arithmetic unit (the `startAR4`/`getA`/`getX`/`putOut`/`readyAR4` block).
- Accepts operand jobs (A, X bytes) from two requesters and grants them round-robin.
- Drives the unit's load/start/display handshake, then waits for completion.
- Holds the result on the unit's hex display for a programmable dwell, and reports done or timeout error to the granted requester.
- Sits between the lab's input front-ends and the arithmetic unit, replacing manual push-button sequencing.

## Interface
- `N`, 16, unit data width; operand bus is N/2 bits.
- `DISP_CYCLES`, 8, cycles `ar4_putOut` is held high per job (≥1).
- `TIMEOUT`, 255, max cycles allowed from START exit to `ar4_ready` returning high (≥2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1: job request, level; held with stable operands until done/err.
- `a0`, `x0`, `a1`, `x1` in N/2: operands A, X of each requester.
- `done0`, `done1` out 1: one-cycle job-complete pulse.
- `err0`, `err1` out 1: one-cycle timeout pulse.
- `busy` out 1: high in every state except IDLE.
- `ar4_start` out 1: start pulse to unit.
- `ar4_getA`, `ar4_getX` out 1: operand-load strobes.
- `ar4_putOut` out 1: display-enable to unit.
- `ar4_inBus` out N/2: operand bus to unit.
- `ar4_ready` in 1: unit idle/finished.

## Operation
States: IDLE, LOAD_A, LOAD_X, START, WAIT_LOW, WAIT_RDY, SHOW, DONE, ERR.

- **IDLE:** grant only if `ar4_ready`=1 and at least one `req` is high.
  - Winner is chosen round-robin from pointer `last`: the requester not served last wins a tie.
  - After reset, `last`=1, so `req0` wins the first tie.
  - The granted index and both operands are latched into internal registers at the grant edge → LOAD_A.
- **LOAD_A:** `ar4_getA`=1, `ar4_inBus`=latched A, one cycle → LOAD_X.
- **LOAD_X:** `ar4_getX`=1, `ar4_inBus`=latched X, one cycle → START.
- **START:** `ar4_start`=1, one cycle; watchdog cleared to 0 → WAIT_LOW.
- **WAIT_LOW:** wait for `ar4_ready`=0 → WAIT_RDY.
- **WAIT_RDY:** wait for `ar4_ready`=1 → SHOW.
- **Watchdog:** a counter of ceil(log2(TIMEOUT+1)) bits increments every cycle in WAIT_LOW/WAIT_RDY.
  - If it equals TIMEOUT while still waiting → ERR.
  - Timeout takes priority over a ready transition in the same cycle.
- **SHOW:** `ar4_putOut`=1 for exactly DISP_CYCLES cycles, using a dwell counter → DONE.
- **DONE:** `doneG`=1 for one cycle for the granted requester; `last`←granted → IDLE.
- **ERR:** `errG`=1 for one cycle; `ar4_putOut`=0; `last`←granted → IDLE.
- **Output rules:**
  - `ar4_inBus`=0 outside LOAD_A/LOAD_X.
  - Strobes are mutually exclusive, and each is high only in its own state.
- **Request handling:**
  - Requests and operands are ignored after the grant edge. A job whose `req` drops mid-flight still completes and still pulses done/err.
  - A requester holding `req` high across its done pulse is re-eligible in the next IDLE but loses any tie, since `last` points to it.

## Timing
- **Reset (`rst`=0, async):**
  - Every output is 0 immediately, including `busy` and `ar4_inBus`.
  - State=IDLE, `last`=1, both counters 0.
  - Reset mid-job abandons the job with no done/err pulse.
- **Grant latency:** `req` high and `ar4_ready` high at edge k → `ar4_getA` high in cycle k+1, `ar4_getX` in k+2, `ar4_start` in k+3.
- **Completion:** with the unit's ready low for L≥1 cycles after start:
  - SHOW begins the cycle after ready is sampled high.
  - `ar4_putOut` is high DISP_CYCLES cycles, then the done pulse follows immediately.
- **Back-to-back jobs:** IDLE is occupied ≥1 cycle between jobs, so the minimum gap between a done pulse and the next `getA` is 1 idle cycle.
- **Ready never low:** if `ar4_ready` never drops after start, the watchdog still expires → ERR after TIMEOUT cycles in WAIT_LOW.
- **Busy unit at IDLE:** `ar4_ready`=0 in IDLE (e.g. unit still busy from reset) holds IDLE; no strobes are issued.

## Test plan
1. **Single job.** Stimulus: `req0`, `a0`=0x12, `x0`=0x34; unit model drops ready for 5 cycles. Required:
   - `getA` with `inBus`=0x12, then `getX` with 0x34, then the `start` pulse.
   - `putOut` high exactly 8 cycles.
   - One `done0` pulse, no `done1`/`err`.
2. **Simultaneous requests.** Stimulus: `req0`+`req1` high from reset, held. Required:
   - Job order req0, req1, req0, …
   - Each grant loads its own operands (0x11/0x22 vs 0xA5/0x5A).
3. **Timeout.** Stimulus: model keeps ready high forever after start. Required:
   - `err0` pulses exactly 255 cycles after START exit.
   - `putOut` never asserted; next `req1` is served normally.
4. **Reset mid-job.** Stimulus: assert `rst`=0 during SHOW. Required:
   - All outputs 0 asynchronously; no `done0`.
   - After release, a simultaneous req0/req1 grants req0 first.
5. **Dropped request and busy unit.** Stimulus: drop `req1` during WAIT_RDY. Required: `done1` still pulses.
   - Separately, hold ready=0 in IDLE with `req0` high: no `getA` until ready=1, then `getA` the next cycle.

Source files
------------

// File: rtl/ar4_job_scheduler.sv
// ar4_job_scheduler
// Two-requester round-robin front end for the four-register shift/add unit.
// A granted job is walked through operand load, start, completion wait and a
// timed result display, then reported back to its requester as done or err.
module ar4_job_scheduler #(
  parameter int N           = 16,
  parameter int DISP_CYCLES = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [N/2-1:0] a0,
  input  logic [N/2-1:0] x0,
  input  logic [N/2-1:0] a1,
  input  logic [N/2-1:0] x1,
  output logic           done0,
  output logic           done1,
  output logic           err0,
  output logic           err1,
  output logic           busy,
  output logic           ar4_start,
  output logic           ar4_getA,
  output logic           ar4_getX,
  output logic           ar4_putOut,
  output logic [N/2-1:0] ar4_inBus,
  input  logic           ar4_ready
);

  localparam int B    = N / 2;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int DW_W = $clog2(DISP_CYCLES + 1);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DISP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_X,
    START,
    WAIT_LOW,
    WAIT_RDY,
    SHOW,
    DONE,
    ERR
  } stateT;

  stateT           state;
  stateT           nextState;
  logic            lastSrv;     // requester served by the most recent job
  logic            grantIdx;    // requester owning the job in flight
  logic            grantEn;
  logic            grantPick;
  logic [B-1:0]    aLat;
  logic [B-1:0]    xLat;
  logic [WD_W-1:0] wdCnt;
  logic [WD_W-1:0] wdNext;
  logic            wdHit;
  logic [DW_W-1:0] dwellCnt;
  logic            waiting;

  // Round-robin pick: on a tie the requester not served last wins.
  assign grantPick = (req0 && req1) ? ~lastSrv : req1;

  // Watchdog expires on the cycle whose increment would reach TIMEOUT, so the
  // wait states occupy exactly TIMEOUT cycles before ERR.
  assign waiting = (state == WAIT_LOW) || (state == WAIT_RDY);
  assign wdNext  = wdCnt + WD_W'(1);
  assign wdHit   = waiting && (wdNext == WD_LIMIT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state decode and Moore outputs; all outputs derive from state so a
  // reset forces them low without waiting for a clock.
  always_comb begin
    // NOTE: every output gets a default here so no path through the case
    // statement leaves a signal unassigned and infers a latch.
    nextState  = state;
    grantEn    = 1'b0;
    ar4_getA   = 1'b0;
    ar4_getX   = 1'b0;
    ar4_start  = 1'b0;
    ar4_putOut = 1'b0;
    ar4_inBus  = '0;
    done0      = 1'b0;
    done1      = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    busy       = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (ar4_ready && (req0 || req1)) begin
          grantEn   = 1'b1;
          nextState = LOAD_A;
        end
      end
      LOAD_A: begin
        ar4_getA  = 1'b1;
        ar4_inBus = aLat;
        nextState = LOAD_X;
      end
      LOAD_X: begin
        ar4_getX  = 1'b1;
        ar4_inBus = xLat;
        nextState = START;
      end
      START: begin
        ar4_start = 1'b1;
        nextState = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (wdHit)           nextState = ERR;
        else if (!ar4_ready) nextState = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (wdHit)          nextState = ERR;
        else if (ar4_ready) nextState = SHOW;
      end
      SHOW: begin
        ar4_putOut = 1'b1;
        if (dwellCnt == DW_LAST) nextState = DONE;
      end
      DONE: begin
        done0     = ~grantIdx;
        done1     = grantIdx;
        nextState = IDLE;
      end
      ERR: begin
        err0      = ~grantIdx;
        err1      = grantIdx;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Control registers: grant owner, round-robin pointer, watchdog, dwell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastSrv  <= 1'b1;
      grantIdx <= 1'b0;
      wdCnt    <= '0;
      dwellCnt <= '0;
    end else begin
      if (grantEn) grantIdx <= grantPick;
      if ((state == DONE) || (state == ERR)) lastSrv <= grantIdx;

      if (state == START) wdCnt <= '0;
      else if (waiting)   wdCnt <= wdNext;

      if (state == SHOW) dwellCnt <= (dwellCnt == DW_LAST) ? '0 : dwellCnt + DW_W'(1);
      else               dwellCnt <= '0;
    end
  end

  // Operand capture at the grant edge; later request/operand changes are ignored.
  always_ff @(posedge clk) begin
    // NOTE: these are pure data registers with no reset; they are only seen on
    // ar4_inBus in the load states, which are always preceded by a grant.
    if (grantEn) begin
      aLat <= grantPick ? a1 : a0;
      xLat <= grantPick ? x1 : x0;
    end
  end

endmodule

// File: tb/tb_ar4_job_scheduler.sv
// Directed bench for ar4_job_scheduler with a small ready-dropping unit model.
module tb_ar4_job_scheduler;

  localparam int N    = 16;
  localparam int B    = N / 2;
  localparam int DISP = 8;
  localparam int TMO  = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [B-1:0] a0 = '0, x0 = '0, a1 = '0, x1 = '0;
  logic         done0, done1, err0, err1, busy;
  logic         ar4_start, ar4_getA, ar4_getX, ar4_putOut;
  logic [B-1:0] ar4_inBus;
  logic         ar4_ready;
  logic         modelReady;
  logic         holdLow = 1'b0;

  int dropMode = 1;
  int lowLen   = 5;

  assign ar4_ready = modelReady && !holdLow;

  ar4_job_scheduler #(.N(N), .DISP_CYCLES(DISP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .x0(x0), .a1(a1), .x1(x1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .busy(busy),
    .ar4_start(ar4_start), .ar4_getA(ar4_getA), .ar4_getX(ar4_getX),
    .ar4_putOut(ar4_putOut), .ar4_inBus(ar4_inBus), .ar4_ready(ar4_ready)
  );

  always #5 clk = ~clk;

  int assertCnt = 0;
  int failCnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outVec();
    return {15'd0, busy, ar4_start, ar4_getA, ar4_getX, ar4_putOut,
            done0, done1, err0, err1, ar4_inBus};
  endfunction

  // Unit model: after a start pulse, ready goes low for lowLen cycles.
  initial begin
    modelReady = 1'b1;
    forever begin
      @(negedge clk);
      if (ar4_start && dropMode != 0) begin
        modelReady = 1'b0;
        repeat (lowLen) @(negedge clk);
        modelReady = 1'b1;
      end
    end
  end

  // Monitor: event counters, timestamps and per-job logs.
  int   cyc = 0, getACnt = 0, putCnt = 0, violCnt = 0;
  int   done0Cnt = 0, done1Cnt = 0, err0Cnt = 0, err1Cnt = 0;
  int   startCyc = 0, firstPutCyc = 0, doneCyc = 0, errCyc = 0;
  logic prevPut = 1'b0;
  int           doneOrder[$];
  logic [B-1:0] aLog[$];
  logic [B-1:0] xLog[$];

  always @(negedge clk) begin
    cyc++;
    if ((32'(ar4_start) + 32'(ar4_getA) + 32'(ar4_getX) + 32'(ar4_putOut)) > 1) violCnt++;
    if (ar4_inBus != '0 && !ar4_getA && !ar4_getX) violCnt++;
    if (ar4_getA) begin getACnt++; aLog.push_back(ar4_inBus); end
    if (ar4_getX) xLog.push_back(ar4_inBus);
    if (ar4_start) startCyc = cyc;
    if (ar4_putOut) begin
      putCnt++;
      if (!prevPut) firstPutCyc = cyc;
    end
    prevPut = ar4_putOut;
    if (done0) begin done0Cnt++; doneCyc = cyc; doneOrder.push_back(0); end
    if (done1) begin done1Cnt++; doneCyc = cyc; doneOrder.push_back(1); end
    if (err0)  begin err0Cnt++;  errCyc = cyc; end
    if (err1)  begin err1Cnt++;  errCyc = cyc; end
  end

  // One cycle step; sample/drive just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Advance until a done/err pulse is visible, bounded by maxCyc cycles.
  task automatic waitEnd(input int maxCyc, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(done0 || done1 || err0 || err1) && n < maxCyc);
    check({tag, "_end_seen"}, 32'(done0 || done1 || err0 || err1), 1);
  endtask

  int p0, d0, d1, e0, oth, g0, base, aBase, n;

  initial begin
    // Reset state
    tick(); tick();
    check("reset_outs", outVec(), 0);
    rst = 1'b1;
    tick();
    check("idle_no_req", outVec(), 0);

    // Single job: exact grant latency, 8-cycle display, one done0
    a0 = 8'h12; x0 = 8'h34; req0 = 1'b1;
    p0 = putCnt; d0 = done0Cnt; oth = done1Cnt + err0Cnt + err1Cnt;
    tick();
    check("t1_getA", {ar4_getA, ar4_getX, ar4_start}, 3'b100);
    check("t1_busA", ar4_inBus, 8'h12);
    tick();
    check("t1_getX", {ar4_getA, ar4_getX, ar4_start}, 3'b010);
    check("t1_busX", ar4_inBus, 8'h34);
    tick();
    check("t1_start", {ar4_getA, ar4_getX, ar4_start}, 3'b001);
    check("t1_bus_idle", ar4_inBus, 0);
    waitEnd(100, "t1");
    req0 = 1'b0;
    check("t1_done0", done0, 1);
    check("t1_put_cycles", putCnt - p0, DISP);
    check("t1_done_cnt", done0Cnt - d0, 1);
    check("t1_show_begin", firstPutCyc - startCyc, 6);
    check("t1_done_after_show", doneCyc - startCyc, 14);
    tick();
    check("t1_pulse_width", {done0, done1, err0, err1}, 0);
    check("t1_other_pulses", done1Cnt + err0Cnt + err1Cnt - oth, 0);
    check("t1_back_idle", busy, 0);

    // Simultaneous requests held from reset
    rst = 1'b0;
    tick();
    a0 = 8'h11; x0 = 8'h22; a1 = 8'hA5; x1 = 8'h5A;
    req0 = 1'b1; req1 = 1'b1;
    base = doneOrder.size(); aBase = aLog.size();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitEnd(100, "t2");
      if (i == 0) begin
        tick();
        check("t2_gap_idle", {busy, ar4_getA}, 0);
        tick();
        check("t2_gap_getA", ar4_getA, 1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t2_jobs", doneOrder.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_order%0d", i), doneOrder[base+i], i % 2);
      check($sformatf("t2_a%0d", i), aLog[aBase+i], (i % 2) ? 8'hA5 : 8'h11);
      check($sformatf("t2_x%0d", i), xLog[aBase+i], (i % 2) ? 8'h5A : 8'h22);
    end
    tick();

    // Timeout: ready never drops
    dropMode = 0;
    a0 = 8'h77; x0 = 8'h88; req0 = 1'b1;
    p0 = putCnt; e0 = err0Cnt; oth = done0Cnt + done1Cnt + err1Cnt;
    waitEnd(400, "t3");
    req0 = 1'b0;
    check("t3_err0", err0, 1);
    check("t3_err_latency", errCyc - startCyc, TMO + 1);
    check("t3_err_cnt", err0Cnt - e0, 1);
    check("t3_no_put", putCnt - p0, 0);
    check("t3_no_done", done0Cnt + done1Cnt + err1Cnt - oth, 0);
    tick();
    check("t3_err_width", err0, 0);
    dropMode = 1; lowLen = 3;
    a1 = 8'h3C; x1 = 8'hC3; req1 = 1'b1;
    aBase = aLog.size();
    waitEnd(100, "t3b");
    req1 = 1'b0;
    check("t3b_done1", done1, 1);
    check("t3b_a1", aLog[aBase], 8'h3C);
    tick();

    // Reset during SHOW
    lowLen = 5;
    a0 = 8'h11; x0 = 8'h22; a1 = 8'hA5; x1 = 8'h5A;
    req0 = 1'b1;
    d0 = done0Cnt;
    n = 0;
    do begin tick(); n++; end while (!ar4_putOut && n < 100);
    check("t4_in_show", ar4_putOut, 1);
    tick();
    rst = 1'b0;
    #1;
    check("t4_async_outs", outVec(), 0);
    req1 = 1'b1;
    tick(); tick(); tick();
    check("t4_held_outs", outVec(), 0);
    check("t4_no_done0", done0Cnt - d0, 0);
    base = doneOrder.size(); aBase = aLog.size();
    rst = 1'b1;
    waitEnd(100, "t4");
    req0 = 1'b0; req1 = 1'b0;
    check("t4_first_done0", done0, 1);
    check("t4_first_a", aLog[aBase], 8'h11);
    tick();

    // Request dropped mid-flight still completes
    lowLen = 10;
    a1 = 8'h66; x1 = 8'h99; req1 = 1'b1;
    d1 = done1Cnt;
    n = 0;
    do begin tick(); n++; end while (!ar4_start && n < 100);
    check("t5_start_seen", ar4_start, 1);
    tick(); tick(); tick();
    req1 = 1'b0;
    waitEnd(100, "t5");
    check("t5_done1", done1, 1);
    check("t5_done1_cnt", done1Cnt - d1, 1);
    tick();

    // Busy unit at IDLE holds off the grant
    lowLen = 5;
    holdLow = 1'b1;
    a0 = 8'h5A; x0 = 8'hA5; req0 = 1'b1;
    g0 = getACnt;
    repeat (6) tick();
    check("t5b_no_getA", getACnt - g0, 0);
    check("t5b_idle", busy, 0);
    holdLow = 1'b0;
    tick();
    check("t5b_getA", ar4_getA, 1);
    check("t5b_busA", ar4_inBus, 8'h5A);
    waitEnd(100, "t5b");
    req0 = 1'b0;
    check("t5b_done0", done0, 1);
    tick();

    check("strobe_exclusive_bus_idle", violCnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
